// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// DMEM_BYTE_WRITE_EN (defined in dmem_responder) adds per-byte store enables.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  // Load data returned with a faulted response.
  localparam logic [WORD_W-1:0] ERR_RDATA = '0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous byte-masked write, combinational read.
// The read port follows idx so the owner can register it on the same edge as a write.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [LANES-1:0]  be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // NOTE: storage is deliberately left out of reset; clearing every word would
  // turn the array into flops instead of a RAM and contents survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: valid/ready request, LATENCY-cycle access, stall and fault flag.
// Optional macro DMEM_BYTE_WRITE_EN adds req_be_i byte enables for stores.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [31:0]       req_addr_i,
  input  logic [WORD_W-1:0] req_wdata_i,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [LANES-1:0]  req_be_i,
`endif
  output logic              rsp_valid_o,
  output logic [WORD_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              stall_o
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 2);

  state_t            state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [LANES-1:0]  be_q;
  logic [LANES-1:0]  be_in;

`ifdef DMEM_BYTE_WRITE_EN
  assign be_in = req_be_i;
`else
  assign be_in = '1;
`endif

  logic              accept;
  logic              enter_resp;
  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic [LANES-1:0]  acc_be;
  logic              fault;
  logic [WORD_W-1:0] arr_rdata;

  assign req_ready_o = (state == IDLE);
  assign accept      = req_ready_o && req_valid_i;
  assign enter_resp  = (accept && LATENCY == 1) || (state == BUSY && cnt == '0);
  assign stall_o     = accept || (state == BUSY);

  // With LATENCY=1 the access completes on the accept edge itself, so the
  // live request is used while idle; otherwise the captured copy is.
  assign acc_we    = req_ready_o ? req_we_i    : we_q;
  assign acc_addr  = req_ready_o ? req_addr_i  : addr_q;
  assign acc_wdata = req_ready_o ? req_wdata_i : wdata_q;
  assign acc_be    = req_ready_o ? be_in       : be_q;
  assign fault     = (acc_addr[1:0] != 2'b00) || (acc_addr >= ADDR_LIMIT);

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk_i),
    .we    (enter_resp && acc_we && !fault),
    .idx   (acc_addr[IDX_W+1:2]),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= enter_resp;
      rsp_err_o   <= enter_resp && fault;
      if (enter_resp) begin
        if (fault)       rsp_rdata_o <= ERR_RDATA;
        else if (acc_we) rsp_rdata_o <= '0;
        else             rsp_rdata_o <= arr_rdata;
      end

      unique case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            be_q    <= be_in;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance checked against a word-array model.
// Build with DMEM_BYTE_WRITE_EN defined to exercise byte-enable stores.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        valid [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        ready [2];
  logic        rvalid[2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic        stall [2];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(valid[0]), .req_ready_o(ready[0]), .req_we_i(we[0]),
    .req_addr_i(addr[0]), .req_wdata_i(wdata[0]),
`ifdef DMEM_BYTE_WRITE_EN
    .req_be_i(be[0]),
`endif
    .rsp_valid_o(rvalid[0]), .rsp_rdata_o(rdata[0]), .rsp_err_o(err[0]), .stall_o(stall[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B)) dut_lat1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(valid[1]), .req_ready_o(ready[1]), .req_we_i(we[1]),
    .req_addr_i(addr[1]), .req_wdata_i(wdata[1]),
`ifdef DMEM_BYTE_WRITE_EN
    .req_be_i(be[1]),
`endif
    .rsp_valid_o(rvalid[1]), .rsp_rdata_o(rdata[1]), .rsp_err_o(err[1]), .stall_o(stall[1])
  );

  // Reference: one word array per instance plus a flag for words with defined contents.
  logic [31:0] mem_m   [2][DEPTH];
  bit          known_m [2][DEPTH];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] eff_be(input logic [3:0] b);
`ifdef DMEM_BYTE_WRITE_EN
    return b;
`else
    return 4'hF;
`endif
  endfunction

  // One complete transaction on instance d; checks handshake, stall, latency and response.
  task automatic access(input int d, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b);
    int          lat;
    bit          flt;
    bit          data_known;
    int          idx;
    int          waited;
    logic [3:0]  m;
    logic [31:0] exp_rd;
    lat        = (d == 0) ? LAT_A : LAT_B;
    flt        = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
    idx        = int'(a[31:2]);
    m          = eff_be(b);
    exp_rd     = 32'h0;
    data_known = 1'b1;
    if (!flt) begin
      if (w) begin
        for (int i = 0; i < 4; i++) if (m[i]) mem_m[d][idx][8*i +: 8] = wd[8*i +: 8];
        known_m[d][idx] = known_m[d][idx] || (m == 4'hF);
      end else begin
        exp_rd     = mem_m[d][idx];
        data_known = known_m[d][idx];
      end
    end

    @(negedge clk);
    valid[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    #1;
    waited = 0;
    while (!ready[d] && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!ready[d]) begin
      check("ready_timeout", 32'(ready[d]), 32'h1);
      valid[d] = 1'b0;
      return;
    end
    check("stall_idle_req", 32'(stall[d]), 32'h1);
    @(posedge clk);

    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      #1;
      check("ready_while_busy", 32'(ready[d]), 32'h0);
      if (k < lat) begin
        check("no_early_rsp", 32'(rvalid[d]), 32'h0);
        check("stall_busy", 32'(stall[d]), 32'h1);
        // Requests presented while busy must be ignored.
        valid[d] = 1'b1; we[d] = 1'($urandom); addr[d] = $urandom;
        wdata[d] = $urandom; be[d] = 4'($urandom);
      end else begin
        check("rsp_valid_at_latency", 32'(rvalid[d]), 32'h1);
        check("stall_resp", 32'(stall[d]), 32'h0);
        check("rsp_err", 32'(err[d]), 32'(flt));
        if (data_known) check("rsp_rdata", rdata[d], exp_rd);
        valid[d] = 1'b0;
      end
    end

    @(negedge clk);
    #1;
    check("rsp_one_cycle", 32'(rvalid[d]), 32'h0);
    check("err_cleared", 32'(err[d]), 32'h0);
    check("ready_after_resp", 32'(ready[d]), 32'h1);
    if (data_known) check("rdata_held", rdata[d], exp_rd);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; be[d] = 4'hF;
      for (int i = 0; i < DEPTH; i++) begin
        mem_m[d][i]   = '0;
        known_m[d][i] = 1'b0;
      end
    end

    // Reset state.
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_ready", 32'(ready[d]), 32'h1);
      check("reset_rsp_valid", 32'(rvalid[d]), 32'h0);
      check("reset_rdata", rdata[d], 32'h0);
      check("reset_err", 32'(err[d]), 32'h0);
      check("reset_stall", 32'(stall[d]), 32'h0);
    end
    rst = 1'b1;

    // Reset mid-op: store to 0x10 aborted one cycle after accept.
    @(negedge clk);
    valid[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'hDEAD_BEEF; be[0] = 4'hF;
    #1 check("midop_ready", 32'(ready[0]), 32'h1);
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    rst = 1'b0;
    #1;
    check("midop_rst_rsp_valid", 32'(rvalid[0]), 32'h0);
    check("midop_rst_rdata", rdata[0], 32'h0);
    check("midop_rst_err", 32'(err[0]), 32'h0);
    check("midop_rst_ready", 32'(ready[0]), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("midop_no_rsp", 32'(rvalid[0]), 32'h0);
      check("midop_ready_after", 32'(ready[0]), 32'h1);
    end
    access(0, 1'b0, 32'h10, 32'h0, 4'hF);
    check("midop_store_dropped", 32'(rdata[0] !== 32'hDEAD_BEEF), 32'h1);

    // Store then load.
    access(0, 1'b1, 32'h20, 32'h1234_5678, 4'hF);
    access(0, 1'b0, 32'h20, 32'h0, 4'hF);
    check("store_load_value", rdata[0], 32'h1234_5678);

    // Faults leave contents untouched.
    access(0, 1'b1, 32'h00, 32'h5A5A_0001, 4'hF);
    access(0, 1'b0, 32'h22, 32'h0, 4'hF);
    access(0, 1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF);
    access(0, 1'b0, 32'h00, 32'h0, 4'hF);
    check("fault_contents_kept", rdata[0], 32'h5A5A_0001);

    // Continuous requests: one accept every LAT_A+1 cycles.
    @(negedge clk);
    valid[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h20; be[0] = 4'hF;
    for (int i = 0; i < 3 * (LAT_A + 1); i++) begin
      int pos;
      pos = i % (LAT_A + 1);
      #1;
      check("held_ready", 32'(ready[0]), 32'(pos == 0));
      check("held_stall", 32'(stall[0]), 32'(pos != LAT_A));
      check("held_rsp_valid", 32'(rvalid[0]), 32'(pos == LAT_A));
      if (pos == LAT_A) check("held_rdata", rdata[0], 32'h1234_5678);
      if (i == 3 * (LAT_A + 1) - 1) valid[0] = 1'b0;
      @(negedge clk);
    end
    #1 check("held_idle_after", 32'(ready[0]), 32'h1);

`ifdef DMEM_BYTE_WRITE_EN
    access(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
    access(0, 1'b0, 32'h20, 32'h0, 4'hF);
    check("be_merge", rdata[0], 32'h12BB_56DD);
    access(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000);
    access(0, 1'b0, 32'h20, 32'h0, 4'hF);
    check("be_none", rdata[0], 32'h12BB_56DD);
`endif

    // LATENCY=1 instance.
    access(1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
    access(1, 1'b0, 32'h20, 32'h0, 4'hF);
    check("lat1_value", rdata[1], 32'hCAFE_F00D);

    // Randomized traffic on both instances.
    for (int n = 0; n < 60; n++) begin
      int          d;
      int          sel;
      logic [31:0] a;
      d   = (n % 3 == 2) ? 1 : 0;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
      else if (sel == 1) a = 32'(DEPTH * 4) + {$urandom_range(0, 1023), 2'b00};
      else               a = {26'h0, 4'($urandom), 2'b00};
      access(d, 1'($urandom), a, $urandom, 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
